// File: rtl/param_stopwatch.sv
// param_stopwatch: parametrised HH:MM:SS.d stopwatch with run-state FSM.
// Counts up or down at TICK_HZ, wraps or saturates at the range ends, and
// presents the digits as {dp, BCD} nibbles for the display multiplexer.
// Optional lap capture is compiled in when STOPWATCH_LAP_EN is defined.
module param_stopwatch #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 10,
  parameter int HOURS_MAX = 24,
  parameter int WRAP_MODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       go,
  input  logic       clr,
  input  logic       lap,
  output logic [4:0] in0,
  output logic [4:0] in1,
  output logic [4:0] in2,
  output logic [4:0] in3,
  output logic [4:0] in4,
  output logic [4:0] in5,
  output logic [4:0] in6,
  output logic [4:0] in7,
  output logic       running,
  output logic       expired,
  output logic       wrap_pulse,
  output logic [4:0] lap0,
  output logic [4:0] lap1,
  output logic [4:0] lap2,
  output logic [4:0] lap3,
  output logic [4:0] lap4,
  output logic [4:0] lap5,
  output logic [4:0] lap6,
  output logic       lap_valid
);

  // Prescaler geometry; DIV is expected to be an integer >= 2.
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  // Largest hour value shown, split into its two BCD digits.
  localparam int HLIM = HOURS_MAX - 1;
  localparam logic [3:0] H1_MAX = 4'(HLIM / 10);
  localparam logic [3:0] H0_MAX = 4'(HLIM % 10);

  localparam bit WRAP_EN = (WRAP_MODE != 0);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  // Next value of one digit when it steps; rolls 9->0 (up) or 0->top (down).
  function automatic logic [3:0] step_digit(input logic [3:0] d,
                                            input logic [3:0] top,
                                            input logic       dir_up);
    logic [3:0] r;
    if (dir_up) begin
      if (d == top) r = 4'd0;
      else          r = d + 4'd1;
    end else begin
      if (d == 4'd0) r = top;
      else           r = d - 4'd1;
    end
    return r;
  endfunction

  // True when a digit is at the point where stepping it carries/borrows.
  function automatic logic digit_rolls(input logic [3:0] d,
                                       input logic [3:0] top,
                                       input logic       dir_up);
    logic r;
    if (dir_up) r = (d == top);
    else        r = (d == 4'd0);
    return r;
  endfunction

  state_e        state_q;
  logic          running_q;
  logic          expired_q;
  logic          wrap_q;
  logic          up_prev_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    tenths_q, tenths_d;
  logic [3:0]    s0_q, s0_d;
  logic [3:0]    s1_q, s1_d;
  logic [3:0]    m0_q, m0_d;
  logic [3:0]    m1_q, m1_d;
  logic [3:0]    h0_q, h0_d;
  logic [3:0]    h1_q, h1_d;

  logic tick_s;
  logic at_max_s;
  logic at_zero_s;
  logic limit_s;
  logic wrap_evt_s;
  logic sat_evt_s;
  logic adv_s0_s, adv_s1_s, adv_m0_s, adv_m1_s, adv_h_s;

  assign tick_s = (state_q == ST_RUN) && (pre_q == PRE_LAST);

  assign at_max_s  = (tenths_q == 4'd9) && (s0_q == 4'd9) && (s1_q == 4'd5) &&
                     (m0_q == 4'd9) && (m1_q == 4'd5) &&
                     (h1_q == H1_MAX) && (h0_q == H0_MAX);
  assign at_zero_s = (tenths_q == 4'd0) && (s0_q == 4'd0) && (s1_q == 4'd0) &&
                     (m0_q == 4'd0) && (m1_q == 4'd0) &&
                     (h1_q == 4'd0) && (h0_q == 4'd0);

  // A tick that would leave the count range in the current direction.
  assign limit_s    = tick_s && (up ? at_max_s : at_zero_s);
  assign wrap_evt_s = limit_s && WRAP_EN;
  assign sat_evt_s  = limit_s && !WRAP_EN;

  // Ripple of carries/borrows up the digit chain.
  assign adv_s0_s = digit_rolls(tenths_q, 4'd9, up);
  assign adv_s1_s = adv_s0_s && digit_rolls(s0_q, 4'd9, up);
  assign adv_m0_s = adv_s1_s && digit_rolls(s1_q, 4'd5, up);
  assign adv_m1_s = adv_m0_s && digit_rolls(m0_q, 4'd9, up);
  assign adv_h_s  = adv_m1_s && digit_rolls(m1_q, 4'd5, up);

  // Prescaler next state: free-runs only in RUN, cleared by clr.
  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (state_q == ST_RUN) begin
      if (pre_q == PRE_LAST) pre_d = '0;
      else                   pre_d = pre_q + PW'(1);
    end else begin
      pre_d = pre_q;
    end
  end

  // Digit chain next state: clear, limit handling, or a normal step.
  always_comb begin
    tenths_d = tenths_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    m0_d     = m0_q;
    m1_d     = m1_q;
    h0_d     = h0_q;
    h1_d     = h1_q;
    if (clr) begin
      tenths_d = 4'd0;
      s0_d     = 4'd0;
      s1_d     = 4'd0;
      m0_d     = 4'd0;
      m1_d     = 4'd0;
      h0_d     = 4'd0;
      h1_d     = 4'd0;
    end else if (limit_s) begin
      if (WRAP_EN && up) begin
        tenths_d = 4'd0;
        s0_d     = 4'd0;
        s1_d     = 4'd0;
        m0_d     = 4'd0;
        m1_d     = 4'd0;
        h0_d     = 4'd0;
        h1_d     = 4'd0;
      end else if (WRAP_EN) begin
        tenths_d = 4'd9;
        s0_d     = 4'd9;
        s1_d     = 4'd5;
        m0_d     = 4'd9;
        m1_d     = 4'd5;
        h0_d     = H0_MAX;
        h1_d     = H1_MAX;
      end else begin
        // Saturating: the count stays put and the FSM expires instead.
        tenths_d = tenths_q;
      end
    end else if (tick_s) begin
      tenths_d = step_digit(tenths_q, 4'd9, up);
      if (adv_s0_s) s0_d = step_digit(s0_q, 4'd9, up);
      else          s0_d = s0_q;
      if (adv_s1_s) s1_d = step_digit(s1_q, 4'd5, up);
      else          s1_d = s1_q;
      if (adv_m0_s) m0_d = step_digit(m0_q, 4'd9, up);
      else          m0_d = m0_q;
      if (adv_m1_s) m1_d = step_digit(m1_q, 4'd5, up);
      else          m1_d = m1_q;
      // Hours never roll here: the range ends were caught by limit_s.
      if (adv_h_s && up) begin
        if (h0_q == 4'd9) begin
          h0_d = 4'd0;
          h1_d = h1_q + 4'd1;
        end else begin
          h0_d = h0_q + 4'd1;
        end
      end else if (adv_h_s) begin
        if (h0_q == 4'd0) begin
          h0_d = 4'd9;
          h1_d = h1_q - 4'd1;
        end else begin
          h0_d = h0_q - 4'd1;
        end
      end else begin
        h0_d = h0_q;
      end
    end else begin
      tenths_d = tenths_q;
    end
  end

  // Count and prescaler registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q    <= '0;
      tenths_q <= 4'd0;
      s0_q     <= 4'd0;
      s1_q     <= 4'd0;
      m0_q     <= 4'd0;
      m1_q     <= 4'd0;
      h0_q     <= 4'd0;
      h1_q     <= 4'd0;
    end else begin
      pre_q    <= pre_d;
      tenths_q <= tenths_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      m0_q     <= m0_d;
      m1_q     <= m1_d;
      h0_q     <= h0_d;
      h1_q     <= h1_d;
    end
  end

  // Run-state FSM with its registered status outputs and the wrap strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_STOPPED;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      wrap_q    <= 1'b0;
      up_prev_q <= 1'b0;
    end else begin
      up_prev_q <= up;
      if (clr) begin
        state_q   <= ST_STOPPED;
        running_q <= 1'b0;
        expired_q <= 1'b0;
        wrap_q    <= 1'b0;
      end else begin
        wrap_q <= wrap_evt_s;
        case (state_q)
          ST_STOPPED: begin
            if (go) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end else begin
              state_q   <= ST_STOPPED;
              running_q <= 1'b0;
            end
            expired_q <= 1'b0;
          end
          ST_RUN: begin
            // Saturation wins over go dropping in the same cycle.
            if (sat_evt_s) begin
              state_q   <= ST_EXPIRED;
              running_q <= 1'b0;
              expired_q <= 1'b1;
            end else if (!go) begin
              state_q   <= ST_STOPPED;
              running_q <= 1'b0;
              expired_q <= 1'b0;
            end else begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
              expired_q <= 1'b0;
            end
          end
          ST_EXPIRED: begin
            // A direction flip releases the limit so the user can count away.
            if (up != up_prev_q) begin
              state_q   <= ST_STOPPED;
              expired_q <= 1'b0;
            end else begin
              state_q   <= ST_EXPIRED;
              expired_q <= 1'b1;
            end
            running_q <= 1'b0;
          end
          default: begin
            state_q   <= ST_STOPPED;
            running_q <= 1'b0;
            expired_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in0 = {1'b0, tenths_q};
  assign in1 = {1'b1, s0_q};
  assign in2 = {1'b0, s1_q};
  assign in3 = {1'b1, m0_q};
  assign in4 = {1'b0, m1_q};
  assign in5 = {1'b1, h0_q};
  assign in6 = {1'b0, h1_q};
  assign in7 = 5'd0;

  assign running    = running_q;
  assign expired    = expired_q;
  assign wrap_pulse = wrap_q;

`ifdef STOPWATCH_LAP_EN
  logic [6:0][4:0] lap_q;
  logic            lap_valid_q;

  // Lap snapshot of the displayed digits; only rst forgets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q       <= '0;
      lap_valid_q <= 1'b0;
    end else if (lap) begin
      lap_q       <= {in6, in5, in4, in3, in2, in1, in0};
      lap_valid_q <= 1'b1;
    end else begin
      lap_q       <= lap_q;
      lap_valid_q <= lap_valid_q;
    end
  end

  assign lap0      = lap_q[0];
  assign lap1      = lap_q[1];
  assign lap2      = lap_q[2];
  assign lap3      = lap_q[3];
  assign lap4      = lap_q[4];
  assign lap5      = lap_q[5];
  assign lap6      = lap_q[6];
  assign lap_valid = lap_valid_q;
`else
  logic lap_unused_s;
  assign lap_unused_s = lap;
  assign lap0      = 5'd0;
  assign lap1      = 5'd0;
  assign lap2      = 5'd0;
  assign lap3      = 5'd0;
  assign lap4      = 5'd0;
  assign lap5      = 5'd0;
  assign lap6      = 5'd0;
  assign lap_valid = 1'b0;
`endif

endmodule
